alu_shift_seq: RTL and testbench
================================

ALU_SHIFT_SEQ -- requirements
Module: alu_shift_seq

Interface
REQ-001 Parameter DRIVE_CYCLES, default 1, range 1..15: number of cycles alu_oe is held in DRIVE.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 nreset  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  request pulse, sampled only in IDLE.
REQ-005 op  input  3  shifter operation code, captured on accepted start.
REQ-006 shift  input  1  1=shift operation, 0=load pass-through; captured on accepted start.
REQ-007 cf  input  1  carry into shifter, captured on accepted start.
REQ-008 abort  input  1  synchronous cancel, any state.
REQ-009 cf_from_shifter  input  1  shifter carry-out.
REQ-010 op543  output  3  registered op to shifter.
REQ-011 cf_in  output  1  registered carry to shifter.
REQ-012 db_drive  output  1  external bus driver enable (source drives db).
REQ-013 alu_shift_oe  output  1  shifter writes into internal high/low buses.
REQ-014 alu_shift_enable  output  1  shifter performs shift.
REQ-015 alu_oe  output  1  ALU drives db.
REQ-016 busy  output  1  high in every state except IDLE.
REQ-017 done  output  1  one-cycle pulse on sequence completion.
REQ-018 cf_out  output  1  carry captured from shifter.

Function
REQ-019 States: IDLE, LOAD, SHIFT, TURN, DRIVE, DONE; encoding is one-hot.
REQ-020 IDLE: start=1 captures op/shift/cf and goes to LOAD next cycle; start in any other state is ignored.
REQ-021 LOAD (1 cycle): db_drive=1, alu_shift_oe=1; alu_shift_enable=shift; next SHIFT if shift=1, else TURN.
REQ-022 SHIFT (1 cycle): db_drive=1, alu_shift_oe=1, alu_shift_enable=1; cf_out<=cf_from_shifter at end of cycle; next TURN.
REQ-023 Pass-through (shift=0): cf_out<=cf captured value, unmodified.
REQ-024 TURN (1 cycle): db_drive=0, alu_oe=0, alu_shift_oe=0; next DRIVE.
REQ-025 DRIVE: alu_oe=1 for exactly DRIVE_CYCLES cycles via 4-bit down-counter loaded on entry; next DONE when counter reaches 0.
REQ-026 DONE (1 cycle): done=1, all bus enables 0; next IDLE; start is not accepted in DONE.
REQ-027 Invariant: db_drive and alu_oe never both 1 in any cycle, including across abort and reset.
REQ-028 Latency start-to-done: 4+DRIVE_CYCLES cycles with shift=1, 3+DRIVE_CYCLES with shift=0 (TURN present).
REQ-029 abort=1: next state IDLE, all enables 0 next cycle, done not asserted, cf_out retains prior value; abort takes priority over start and all transitions.
REQ-030 op543 and cf_in hold captured values until the next accepted start.
REQ-031 Outputs are registered; no combinational path from inputs to outputs.

Reset
REQ-032 nreset low: state=IDLE, counter=0, op543=0, cf_in=0, cf_out=0, all enables 0, busy=0, done=0, immediately and asynchronously.
REQ-033 Reset mid-sequence discards the operation; first start after release is accepted normally.

Configuration
REQ-034 Macro ALU_SEQ_TURNAROUND_EN defined: TURN state present as in REQ-024.
REQ-035 Macro ALU_SEQ_TURNAROUND_EN undefined: TURN state omitted, LOAD/SHIFT go directly to DRIVE, latency reduced by 1; REQ-027 still holds.

Structure
REQ-036 Shared package alu_pkg holds state enum type, op543 code constants and DRIVE counter width constant.
REQ-037 No sub-module; optional counter kept inline in the FSM module.

Verification
REQ-038 Reset: nreset low mid-DRIVE -> all outputs 0 same cycle, state IDLE, busy=0.
REQ-039 Shift op: start, op=3'b000, cf=1, shift=1, DRIVE_CYCLES=1, shifter cf 0 -> LOAD,SHIFT,TURN,DRIVE,DONE; done at cycle 5; cf_out=0.
REQ-040 Pass-through: start, shift=0, cf=1, DRIVE_CYCLES=3 -> alu_shift_enable never 1, alu_oe high 3 cycles, done at cycle 6, cf_out=1.
REQ-041 Abort in SHIFT -> next cycle IDLE, enables 0, done never pulses, cf_out unchanged.
REQ-042 start held high continuously -> new sequence accepted only from IDLE, one cycle after each done; start in DONE ignored.
REQ-043 Assertion every cycle: !(db_drive && alu_oe), with and without ALU_SEQ_TURNAROUND_EN.

Source files
------------

// File: rtl/alu_shift_seq_pkg.sv
// Shared types and constants for the shifter bus sequencer.
package alu_pkg;

    typedef enum logic [5:0] {
        S_IDLE  = 6'b000001,
        S_LOAD  = 6'b000010,
        S_SHIFT = 6'b000100,
        S_TURN  = 6'b001000,
        S_DRIVE = 6'b010000,
        S_DONE  = 6'b100000
    } state_t;

    // Shifter op543 codes (rotate / shift family)
    localparam logic [2:0] OP_RLC = 3'd0;
    localparam logic [2:0] OP_RRC = 3'd1;
    localparam logic [2:0] OP_RL  = 3'd2;
    localparam logic [2:0] OP_RR  = 3'd3;
    localparam logic [2:0] OP_SLA = 3'd4;
    localparam logic [2:0] OP_SRA = 3'd5;
    localparam logic [2:0] OP_SLL = 3'd6;
    localparam logic [2:0] OP_SRL = 3'd7;

    localparam int CNT_W = 4;

endpackage

// File: rtl/alu_shift_seq_if.sv
// Request/control bundle between a requester, the sequencer and the shifter.
interface alu_shift_seq_if;
    logic       start;
    logic [2:0] op;
    logic       shift;
    logic       cf;
    logic       abort;
    logic       cf_from_shifter;
    logic [2:0] op543;
    logic       cf_in;
    logic       db_drive;
    logic       alu_shift_oe;
    logic       alu_shift_enable;
    logic       alu_oe;
    logic       busy;
    logic       done;
    logic       cf_out;

    modport master (
        output start, op, shift, cf, abort, cf_from_shifter,
        input  op543, cf_in, db_drive, alu_shift_oe, alu_shift_enable,
               alu_oe, busy, done, cf_out
    );

    modport slave (
        input  start, op, shift, cf, abort, cf_from_shifter,
        output op543, cf_in, db_drive, alu_shift_oe, alu_shift_enable,
               alu_oe, busy, done, cf_out
    );
endinterface

// File: rtl/alu_shift_seq.sv
// Load/shift/turnaround/drive sequencer for the shifter data path.
// Build option: ALU_SEQ_TURNAROUND_EN inserts a dead TURN cycle before DRIVE.
module alu_shift_seq
    import alu_pkg::*;
#(
    parameter int DRIVE_CYCLES = 1
) (
    input  logic            clk,
    input  logic            nreset,
    alu_shift_seq_if.slave  bus
);

`ifdef ALU_SEQ_TURNAROUND_EN
    localparam state_t S_AFTER = S_TURN;
`else
    localparam state_t S_AFTER = S_DRIVE;
`endif

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DRIVE_CYCLES - 1);

    state_t           state, nxt;
    logic             shift_q;
    logic             shift_sel;
    logic [CNT_W-1:0] cnt;
    logic             accept;
    logic             db_n, soe_n, sen_n, aoe_n, busy_n, done_n;

    assign accept    = (state == S_IDLE) && bus.start && !bus.abort;
    assign shift_sel = (state == S_IDLE) ? bus.shift : shift_q;

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state   <= S_IDLE;
            cnt     <= '0;
            shift_q <= 1'b0;
        end else begin
            state <= nxt;
            if (accept) shift_q <= bus.shift;
            if (bus.abort)
                cnt <= '0;
            else if (nxt == S_DRIVE && state != S_DRIVE)
                cnt <= CNT_LOAD;
            else if (state == S_DRIVE && cnt != '0)
                cnt <= cnt - 1'b1;
        end
    end

    always_comb begin
        nxt = state;
        if (bus.abort) begin
            nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE:  if (bus.start) nxt = S_LOAD;
                S_LOAD:  nxt = shift_q ? S_SHIFT : S_AFTER;
                S_SHIFT: nxt = S_AFTER;
                S_TURN:  nxt = S_DRIVE;
                S_DRIVE: if (cnt == '0) nxt = S_DONE;
                S_DONE:  nxt = S_IDLE;
                default: nxt = S_IDLE;
            endcase
        end
    end

    // Outputs decode the upcoming state so they can be registered with it.
    always_comb begin
        db_n   = (nxt == S_LOAD) || (nxt == S_SHIFT);
        soe_n  = db_n;
        sen_n  = ((nxt == S_LOAD) && shift_sel) || (nxt == S_SHIFT);
        aoe_n  = (nxt == S_DRIVE);
        busy_n = (nxt != S_IDLE);
        done_n = (nxt == S_DONE);
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            bus.op543            <= OP_RLC;
            bus.cf_in            <= 1'b0;
            bus.cf_out           <= 1'b0;
            bus.db_drive         <= 1'b0;
            bus.alu_shift_oe     <= 1'b0;
            bus.alu_shift_enable <= 1'b0;
            bus.alu_oe           <= 1'b0;
            bus.busy             <= 1'b0;
            bus.done             <= 1'b0;
        end else begin
            bus.db_drive         <= db_n;
            bus.alu_shift_oe     <= soe_n;
            bus.alu_shift_enable <= sen_n;
            bus.alu_oe           <= aoe_n;
            bus.busy             <= busy_n;
            bus.done             <= done_n;
            if (accept) begin
                bus.op543 <= bus.op;
                bus.cf_in <= bus.cf;
            end
            // Carry result: shifter output for shifts, captured carry otherwise.
            if (!bus.abort) begin
                if (state == S_SHIFT)
                    bus.cf_out <= bus.cf_from_shifter;
                else if (state == S_LOAD && !shift_q)
                    bus.cf_out <= bus.cf_in;
            end
        end
    end

endmodule

// File: tb/tb_alu_shift_seq.sv
// Directed bench for alu_shift_seq: two instances (DRIVE_CYCLES 1 and 3) on shared stimulus.
module tb_alu_shift_seq;
    import alu_pkg::*;

`ifdef ALU_SEQ_TURNAROUND_EN
    localparam int TA = 1;
`else
    localparam int TA = 0;
`endif

    logic       clk = 1'b0;
    logic       nreset = 1'b0;
    logic       start = 1'b0;
    logic [2:0] op = 3'd0;
    logic       shift = 1'b0;
    logic       cf = 1'b0;
    logic       abort = 1'b0;
    logic       cfs = 1'b0;
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    alu_shift_seq_if b1();
    alu_shift_seq_if b3();

    assign b1.start = start;  assign b3.start = start;
    assign b1.op    = op;     assign b3.op    = op;
    assign b1.shift = shift;  assign b3.shift = shift;
    assign b1.cf    = cf;     assign b3.cf    = cf;
    assign b1.abort = abort;  assign b3.abort = abort;
    assign b1.cf_from_shifter = cfs;
    assign b3.cf_from_shifter = cfs;

    alu_shift_seq #(.DRIVE_CYCLES(1)) u1 (.clk(clk), .nreset(nreset), .bus(b1.slave));
    alu_shift_seq #(.DRIVE_CYCLES(3)) u3 (.clk(clk), .nreset(nreset), .bus(b3.slave));

    // {op543, cf_in, db_drive, alu_shift_oe, alu_shift_enable, alu_oe, busy, done, cf_out}
    function automatic logic [10:0] mk(logic [2:0] o, logic ci, logic db, logic soe,
                                       logic sen, logic aoe, logic bsy, logic dn, logic co);
        return {o, ci, db, soe, sen, aoe, bsy, dn, co};
    endfunction

    function automatic logic [10:0] obs1();
        return {b1.op543, b1.cf_in, b1.db_drive, b1.alu_shift_oe, b1.alu_shift_enable,
                b1.alu_oe, b1.busy, b1.done, b1.cf_out};
    endfunction

    function automatic logic [10:0] obs3();
        return {b3.op543, b3.cf_in, b3.db_drive, b3.alu_shift_oe, b3.alu_shift_enable,
                b3.alu_oe, b3.busy, b3.done, b3.cf_out};
    endfunction

    // Expected outputs c cycles after the accepting edge of one sequence.
    function automatic logic [10:0] model(int c, int dc, logic sh, logic [2:0] o,
                                          logic ci, logic co0, logic co1);
        int   l;
        logic co;
        l  = 1 + int'(sh) + TA + dc + 1;
        co = (c >= (sh ? 3 : 2)) ? co1 : co0;
        if (c > l)             return mk(o, ci, 0, 0, 0, 0, 0, 0, co);
        if (c == 1)            return mk(o, ci, 1, 1, sh, 0, 1, 0, co);
        if (sh && c == 2)      return mk(o, ci, 1, 1, 1, 0, 1, 0, co);
        if (c == l)            return mk(o, ci, 0, 0, 0, 0, 1, 1, co);
        if (c > l - 1 - dc)    return mk(o, ci, 0, 0, 0, 1, 1, 0, co);
        return mk(o, ci, 0, 0, 0, 0, 1, 0, co);
    endfunction

    task automatic chk(string tag, logic [10:0] o, logic [10:0] e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, o, e);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run(string name, logic sh, logic [2:0] o, logic ci,
                       logic co0, logic co1, int ncyc);
        start = 1'b1; shift = sh; op = o; cf = ci;
        for (int c = 1; c <= ncyc; c++) begin
            tick();
            start = 1'b0;
            chk($sformatf("%s_u1_c%0d", name, c), obs1(), model(c, 1, sh, o, ci, co0, co1));
            chk($sformatf("%s_u3_c%0d", name, c), obs3(), model(c, 3, sh, o, ci, co0, co1));
        end
    endtask

    always @(negedge clk) begin
        checks++;
        assert (!(b1.db_drive && b1.alu_oe) && !(b3.db_drive && b3.alu_oe)) else begin
            errors++;
            $error("FAIL bus_conflict observed=%b%b%b%b expected=no_overlap",
                   b1.db_drive, b1.alu_oe, b3.db_drive, b3.alu_oe);
        end
    end

    initial begin
        logic [10:0] idle_v;
        int          p1, p3;

        #2;
        chk("reset_u1", obs1(), 11'd0);
        chk("reset_u3", obs3(), 11'd0);
        tick();
        nreset = 1'b1;
        tick();

        // Pass-through with carry set: no shift enable, carry copied
        run("pass", 1'b0, OP_SRA, 1'b1, 1'b0, 1'b1, 6 + TA);

        // Shift with shifter carry-out 0 overriding prior cf_out=1
        cfs = 1'b0;
        run("shift", 1'b1, OP_RLC, 1'b1, 1'b1, 1'b0, 7 + TA);

        // Abort during SHIFT: shifter carry 1 must not land in cf_out
        cfs = 1'b1;
        start = 1'b1; shift = 1'b1; op = OP_RL; cf = 1'b0;
        tick();
        start = 1'b0;
        chk("abort_load_u1", obs1(), model(1, 1, 1'b1, OP_RL, 1'b0, 1'b0, 1'b1));
        tick();
        chk("abort_shift_u1", obs1(), model(2, 1, 1'b1, OP_RL, 1'b0, 1'b0, 1'b1));
        abort = 1'b1;
        tick();
        abort = 1'b0;
        idle_v = mk(OP_RL, 1'b0, 0, 0, 0, 0, 0, 0, 1'b0);
        chk("abort_u1", obs1(), idle_v);
        chk("abort_u3", obs3(), idle_v);
        for (int c = 0; c < 6; c++) begin
            tick();
            chk($sformatf("abort_quiet_u1_%0d", c), obs1(), idle_v);
            chk($sformatf("abort_quiet_u3_%0d", c), obs3(), idle_v);
        end

        // Abort wins over start in IDLE: nothing captured
        start = 1'b1; abort = 1'b1; op = OP_SLL; cf = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        chk("abort_start_u1", obs1(), idle_v);
        chk("abort_start_u3", obs3(), idle_v);

        // Start held high: re-accepted only from the IDLE cycle after DONE
        p1 = 4 + TA;
        p3 = 6 + TA;
        start = 1'b1; shift = 1'b0; op = OP_SRL; cf = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            tick();
            chk($sformatf("held_u1_c%0d", c), obs1(),
                model(((c - 1) % p1) + 1, 1, 1'b0, OP_SRL, 1'b1, (c > p1) ? 1'b1 : 1'b0, 1'b1));
            chk($sformatf("held_u3_c%0d", c), obs3(),
                model(((c - 1) % p3) + 1, 3, 1'b0, OP_SRL, 1'b1, (c > p3) ? 1'b1 : 1'b0, 1'b1));
        end
        start = 1'b0;
        for (int c = 0; c < 8; c++) tick();

        // Reset while u3 is mid-DRIVE
        cfs = 1'b0;
        start = 1'b1; shift = 1'b1; op = OP_RR; cf = 1'b1;
        for (int c = 1; c <= 4 + TA; c++) begin
            tick();
            start = 1'b0;
        end
        chk("pre_reset_u1", obs1(), model(4 + TA, 1, 1'b1, OP_RR, 1'b1, 1'b1, 1'b0));
        chk("pre_reset_u3", obs3(), model(4 + TA, 3, 1'b1, OP_RR, 1'b1, 1'b1, 1'b0));
        nreset = 1'b0;
        #1;
        chk("mid_reset_u1", obs1(), 11'd0);
        chk("mid_reset_u3", obs3(), 11'd0);
        tick();
        nreset = 1'b1;
        start = 1'b1; shift = 1'b0; op = OP_RRC; cf = 1'b0;
        tick();
        start = 1'b0;
        chk("post_reset_u1", obs1(), model(1, 1, 1'b0, OP_RRC, 1'b0, 1'b0, 1'b0));
        chk("post_reset_u3", obs3(), model(1, 3, 1'b0, OP_RRC, 1'b0, 1'b0, 1'b0));
        for (int c = 0; c < 8; c++) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
